// File: rtl/llc_arbiter.sv
// llc_arbiter: shares one LLC read/write service port among NUM_REQ requesters
module llc_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W = 64,
  parameter int LINE_W = 512,
  parameter int MAX_WR_STREAK = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_r_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_r_addr,
  output logic [NUM_REQ-1:0]        req_r_done,
  output logic [LINE_W-1:0]         req_r_data,
  input  logic [NUM_REQ-1:0]        req_w_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_w_addr,
  input  logic [NUM_REQ*LINE_W-1:0] req_w_data,
  output logic [NUM_REQ-1:0]        req_w_done,
  output logic [ADDR_W-1:0]         llc_r_addr,
  output logic                      llc_r_addr_valid,
  input  logic [LINE_W-1:0]         llc_r_data,
  input  logic                      llc_r_data_valid,
  output logic                      llc_w_valid,
  output logic [ADDR_W-1:0]         llc_w_addr,
  output logic [LINE_W-1:0]         llc_w_data,
  input  logic                      llc_w_ready
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3;
  localparam int SW = $clog2(MAX_WR_STREAK + 1);
  logic [1:0] state;
  logic is_wr;
  logic [ID_W-1:0] id, rd_ptr, wr_ptr, r_pick, w_pick;
  logic r_any, w_any, grant_w;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [SW-1:0] wr_streak;
  function automatic logic [ID_W-1:0] nxt(input logic [ID_W-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction
  // round-robin pick per type: smallest offset from the pointer wins, so scan offsets high to low
  always_comb begin
    r_pick = '0;
    w_pick = '0;
    r_any = 1'b0;
    w_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_r_valid[(int'(rd_ptr) + i) % NUM_REQ]) begin
        r_any = 1'b1;
        r_pick = ID_W'((int'(rd_ptr) + i) % NUM_REQ);
      end
      if (req_w_valid[(int'(wr_ptr) + i) % NUM_REQ]) begin
        w_any = 1'b1;
        w_pick = ID_W'((int'(wr_ptr) + i) % NUM_REQ);
      end
    end
    grant_w = w_any && !(r_any && wr_streak == SW'(MAX_WR_STREAK));
  end
  // transaction FSM: grant in IDLE, one LLC op, one-cycle response
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      is_wr <= 1'b0;
      id <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      wr_streak <= '0;
      addr <= '0;
      wdata <= '0;
      req_r_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_w) begin
            state <= WR;
            is_wr <= 1'b1;
            id <= w_pick;
            addr <= req_w_addr[int'(w_pick)*ADDR_W +: ADDR_W];
            wdata <= req_w_data[int'(w_pick)*LINE_W +: LINE_W];
            wr_ptr <= nxt(w_pick);
            wr_streak <= (wr_streak == SW'(MAX_WR_STREAK)) ? wr_streak : wr_streak + 1'b1;
          end else if (r_any) begin
            state <= RD;
            is_wr <= 1'b0;
            id <= r_pick;
            addr <= req_r_addr[int'(r_pick)*ADDR_W +: ADDR_W];
            rd_ptr <= nxt(r_pick);
            wr_streak <= '0;
          end
        end
        RD: begin
          if (llc_r_data_valid) begin
            req_r_data <= llc_r_data;
            state <= RESP;
          end
        end
        WR: state <= llc_w_ready ? RESP : WR;
        RESP: state <= IDLE;
      endcase
    end
  end
  assign llc_r_addr_valid = state == RD;
  assign llc_w_valid = state == WR;
  assign llc_r_addr = addr;
  assign llc_w_addr = addr;
  assign llc_w_data = wdata;
  assign req_r_done = (state == RESP && !is_wr) ? NUM_REQ'(1) << id : '0;
  assign req_w_done = (state == RESP && is_wr) ? NUM_REQ'(1) << id : '0;
endmodule

// File: tb/tb_llc_arbiter.sv
// tb_llc_arbiter: directed cycle-table and corner-case sequences for llc_arbiter
module tb_llc_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req_r_valid = '0, req_w_valid = '0, req_r_done, req_w_done;
  logic [127:0] req_r_addr = {64'h2000, 64'h1000};
  logic [127:0] req_w_addr = {64'h4000, 64'h3000};
  logic [511:0] wd0 = {16{32'hD0D0_0000}}, wd1 = {16{32'hD1D1_1111}};
  logic [1023:0] req_w_data;
  logic [511:0] req_r_data, llc_r_data = '0, llc_w_data;
  logic [63:0] llc_r_addr, llc_w_addr;
  logic llc_r_addr_valid, llc_w_valid;
  logic llc_r_data_valid = 1'b0, llc_w_ready = 1'b0;
  logic [511:0] pat = {8{64'hCAFE_F00D_1234_5678}};
  int n_cmp = 0, n_fail = 0;
  assign req_w_data = {wd1, wd0};
  always #5 clk = ~clk;
  llc_arbiter dut (
    .clk(clk), .reset(reset),
    .req_r_valid(req_r_valid), .req_r_addr(req_r_addr), .req_r_done(req_r_done), .req_r_data(req_r_data),
    .req_w_valid(req_w_valid), .req_w_addr(req_w_addr), .req_w_data(req_w_data), .req_w_done(req_w_done),
    .llc_r_addr(llc_r_addr), .llc_r_addr_valid(llc_r_addr_valid), .llc_r_data(llc_r_data),
    .llc_r_data_valid(llc_r_data_valid), .llc_w_valid(llc_w_valid), .llc_w_addr(llc_w_addr),
    .llc_w_data(llc_w_data), .llc_w_ready(llc_w_ready)
  );
  typedef struct {
    logic [1:0] rv, wv;
    logic rdv, wrdy, rav, wvo;
    logic [1:0] rd, wd;
    logic [63:0] addr;
  } vec_t;
  vec_t tbl[33];
  task automatic chk(input string nm, input logic [511:0] a, input logic [511:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_ctl(input string nm, input logic rav, input logic wvo, input logic [1:0] rd, input logic [1:0] wd);
    chk({nm, " r_addr_valid"}, 512'(llc_r_addr_valid), 512'(rav));
    chk({nm, " w_valid"}, 512'(llc_w_valid), 512'(wvo));
    chk({nm, " r_done"}, 512'(req_r_done), 512'(rd));
    chk({nm, " w_done"}, 512'(req_w_done), 512'(wd));
  endtask
  initial begin
    tbl[0]  = '{2'b01, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[1]  = '{2'b01, 2'b00, 1, 1, 1, 0, 2'b00, 2'b00, 64'h1000};
    tbl[2]  = '{2'b01, 2'b00, 1, 1, 0, 0, 2'b01, 2'b00, 64'h0};
    tbl[3]  = '{2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[4]  = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[5]  = '{2'b11, 2'b00, 1, 1, 1, 0, 2'b00, 2'b00, 64'h2000};
    tbl[6]  = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b10, 2'b00, 64'h0};
    tbl[7]  = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[8]  = '{2'b11, 2'b00, 1, 1, 1, 0, 2'b00, 2'b00, 64'h1000};
    tbl[9]  = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b01, 2'b00, 64'h0};
    tbl[10] = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[11] = '{2'b11, 2'b00, 1, 1, 1, 0, 2'b00, 2'b00, 64'h2000};
    tbl[12] = '{2'b11, 2'b00, 1, 1, 0, 0, 2'b10, 2'b00, 64'h0};
    tbl[13] = '{2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[14] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[15] = '{2'b01, 2'b11, 1, 1, 0, 1, 2'b00, 2'b00, 64'h3000};
    tbl[16] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b01, 64'h0};
    tbl[17] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[18] = '{2'b01, 2'b11, 1, 1, 0, 1, 2'b00, 2'b00, 64'h4000};
    tbl[19] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b10, 64'h0};
    tbl[20] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[21] = '{2'b01, 2'b11, 1, 1, 0, 1, 2'b00, 2'b00, 64'h3000};
    tbl[22] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b01, 64'h0};
    tbl[23] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[24] = '{2'b01, 2'b11, 1, 1, 0, 1, 2'b00, 2'b00, 64'h4000};
    tbl[25] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b10, 64'h0};
    tbl[26] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[27] = '{2'b01, 2'b11, 1, 1, 1, 0, 2'b00, 2'b00, 64'h1000};
    tbl[28] = '{2'b01, 2'b11, 1, 1, 0, 0, 2'b01, 2'b00, 64'h0};
    tbl[29] = '{2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    tbl[30] = '{2'b00, 2'b11, 1, 1, 0, 1, 2'b00, 2'b00, 64'h3000};
    tbl[31] = '{2'b00, 2'b11, 1, 1, 0, 0, 2'b00, 2'b01, 64'h0};
    tbl[32] = '{2'b00, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 64'h0};
    step;
    step;
    @(negedge clk);
    chk_ctl("reset", 0, 0, 2'b00, 2'b00);
    chk("reset r_data", req_r_data, '0);
    step;
    reset = 1'b0;
    for (int k = 0; k < 33; k++) begin
      req_r_valid = tbl[k].rv;
      req_w_valid = tbl[k].wv;
      llc_r_data_valid = tbl[k].rdv;
      llc_w_ready = tbl[k].wrdy;
      @(negedge clk);
      chk_ctl($sformatf("row%0d", k), tbl[k].rav, tbl[k].wvo, tbl[k].rd, tbl[k].wd);
      if (tbl[k].rav) chk($sformatf("row%0d r_addr", k), 512'(llc_r_addr), 512'(tbl[k].addr));
      if (tbl[k].wvo) chk($sformatf("row%0d w_addr", k), 512'(llc_w_addr), 512'(tbl[k].addr));
      step;
    end
    req_r_valid = 2'b10;
    llc_r_data_valid = 1'b0;
    llc_r_data = pat;
    @(negedge clk);
    chk_ctl("miss idle", 0, 0, 2'b00, 2'b00);
    step;
    for (int i = 0; i < 20; i++) begin
      llc_r_data_valid = (i == 19);
      @(negedge clk);
      chk_ctl($sformatf("miss%0d", i), 1, 0, 2'b00, 2'b00);
      chk($sformatf("miss%0d r_addr", i), 512'(llc_r_addr), 512'(64'h2000));
      step;
    end
    llc_r_data_valid = 1'b0;
    @(negedge clk);
    chk_ctl("miss resp", 0, 0, 2'b10, 2'b00);
    chk("miss r_data", req_r_data, pat);
    step;
    req_r_valid = 2'b00;
    llc_r_data = '0;
    @(negedge clk);
    chk_ctl("miss after", 0, 0, 2'b00, 2'b00);
    chk("miss r_data hold", req_r_data, pat);
    step;
    req_w_valid = 2'b01;
    llc_w_ready = 1'b0;
    @(negedge clk);
    chk_ctl("bp idle", 0, 0, 2'b00, 2'b00);
    step;
    for (int i = 0; i < 6; i++) begin
      llc_w_ready = (i == 5);
      @(negedge clk);
      chk_ctl($sformatf("bp%0d", i), 0, 1, 2'b00, 2'b00);
      if (i == 0) begin
        chk("bp w_addr", 512'(llc_w_addr), 512'(64'h3000));
        chk("bp w_data", llc_w_data, wd0);
      end
      step;
    end
    llc_w_ready = 1'b0;
    @(negedge clk);
    chk_ctl("bp resp", 0, 0, 2'b00, 2'b01);
    step;
    req_w_valid = 2'b00;
    req_r_valid = 2'b01;
    llc_r_data_valid = 1'b0;
    @(negedge clk);
    chk_ctl("rst idle", 0, 0, 2'b00, 2'b00);
    step;
    @(negedge clk);
    chk_ctl("rst rd", 1, 0, 2'b00, 2'b00);
    reset = 1'b1;
    step;
    @(negedge clk);
    chk_ctl("rst out", 0, 0, 2'b00, 2'b00);
    chk("rst r_data", req_r_data, '0);
    chk("rst r_addr", 512'(llc_r_addr), '0);
    chk("rst w_data", llc_w_data, '0);
    step;
    reset = 1'b0;
    req_r_valid = 2'b11;
    llc_r_data_valid = 1'b1;
    llc_r_data = ~pat;
    @(negedge clk);
    chk_ctl("fresh idle", 0, 0, 2'b00, 2'b00);
    step;
    @(negedge clk);
    chk_ctl("fresh rd", 1, 0, 2'b00, 2'b00);
    chk("fresh r_addr", 512'(llc_r_addr), 512'(64'h1000));
    step;
    @(negedge clk);
    chk_ctl("fresh resp", 0, 0, 2'b01, 2'b00);
    chk("fresh r_data", req_r_data, ~pat);
    step;
    req_r_valid = 2'b00;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/llc_arbiter.md
Name: llc_arbiter

Overview:
- Shares the single last-level-cache service port among NUM_REQ upstream requesters (instruction-fetch and data L1 miss paths).
- Accepts line-granular read and write requests from each requester and serialises them onto the LLC read/write service interface, one transaction in flight at a time.
- Arbitration: writes have priority over reads, with a streak limit to bound read starvation; round-robin among requesters within each type.
- Returns read line data and completion pulses to the originating requester.

Parameters:
- NUM_REQ, 2, number of requesters (≥2).
- ADDR_W, 64, byte-address width.
- LINE_W, 512, cache-line width in bits.
- MAX_WR_STREAK, 4, max consecutive write grants while any read is pending.
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_r_valid  in  NUM_REQ  per-requester read request, held until matching req_r_done.
- req_r_addr  in  NUM_REQ*ADDR_W  per-requester read line address, stable while valid.
- req_r_done  out  NUM_REQ  one-cycle pulse: read complete, req_r_data valid.
- req_r_data  out  LINE_W  registered line data, shared by all requesters.
- req_w_valid  in  NUM_REQ  per-requester write request, held until req_w_done.
- req_w_addr  in  NUM_REQ*ADDR_W  write line address.
- req_w_data  in  NUM_REQ*LINE_W  write line data.
- req_w_done  out  NUM_REQ  one-cycle pulse: write accepted by LLC.
- llc_r_addr  out  ADDR_W  LLC read address.
- llc_r_addr_valid  out  1  LLC read request, held until llc_r_data_valid.
- llc_r_data  in  LINE_W  LLC read data.
- llc_r_data_valid  in  1  LLC hit/data-valid (combinational in LLC).
- llc_w_valid  out  1  LLC write request.
- llc_w_addr  out  ADDR_W  LLC write address.
- llc_w_data  out  LINE_W  LLC write data.
- llc_w_ready  in  1  LLC able to accept a write this cycle.

Behaviour:
- Reset: all outputs 0; state IDLE; rd_ptr=wr_ptr=0; wr_streak=0. Reset mid-transaction abandons the LLC transaction; no done pulse is issued.
- States: IDLE, RD, WR, RESP. All outputs are registered or decoded from registered state/latches.
- IDLE: samples req_*_valid only in this state.
  - Grant write when any req_w_valid and not (any req_r_valid and wr_streak==MAX_WR_STREAK); otherwise grant read when any req_r_valid.
  - Within a type: first set bit at or after the type's ptr, wrapping modulo NUM_REQ.
  - On grant: latch id, addr (plus data for writes); ptr_type <= id+1 mod NUM_REQ; go to WR or RD.
  - wr_streak increments on a write grant (saturating at MAX_WR_STREAK) and clears on a read grant.
- RD: llc_r_addr_valid=1, llc_r_addr=latched addr.
  - When llc_r_data_valid is sampled high: capture llc_r_data into req_r_data, go to RESP.
  - An LLC miss simply holds RD. There is no timeout.
- WR: llc_w_valid=1 with latched addr/data.
  - When llc_w_ready is sampled high: go to RESP. llc_w_valid drops in RESP.
- RESP: exactly one cycle.
  - Pulse req_r_done[id] or req_w_done[id]; req_r_data is stable from RESP until the next read capture.
  - Then go to IDLE.
- Requester contract: deassert valid (or present a new request) at the edge ending the RESP cycle. A requester with both read and write valid is served as two independent transactions.
- Latency:
  - Read hit: request visible in IDLE at cycle 0, llc_r_addr_valid at cycle 1, done at cycle 2.
  - Write with ready: llc_w_valid at cycle 1, done at cycle 2.
  - Back-to-back grants are spaced at least 3 cycles apart (IDLE/op/RESP).
- Only one LLC request is asserted at any time; llc_r_addr_valid and llc_w_valid are never both 1.
- Valid-dropping before done is a protocol violation; the arbiter completes the latched transaction regardless.

Test Plan:
- Single read, req_r_valid=01, addr 0x1000, LLC hits immediately → llc_r_addr_valid cycles 1–1, req_r_done=01 at cycle 2, req_r_data equals LLC line.
- Read miss, LLC asserts data_valid after 20 cycles → llc_r_addr_valid held 20 cycles with stable addr; exactly one done pulse.
- Both requesters read continuously → grants alternate 0,1,0,1; each done pulse goes to the correct bit.
- req_w_valid=11 held continuously with req_r_valid=01, MAX_WR_STREAK=4 → grant order W0,W1,W0,W1,R0, then writes resume.
- Write with llc_w_ready=0 for 5 cycles then 1 → llc_w_valid held 6 cycles, req_w_done pulses the cycle after acceptance.
- Reset asserted during RD → next cycle all outputs 0, no done pulse; a fresh request afterwards is granted to requester 0.
